// File: rtl/simple_core_pkg.sv
// Shared types for the simple core: opcodes, instruction layout, sequencer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simple_core_pkg;

  localparam int IMM_WIDTH   = 14;
  localparam int INSTR_WIDTH = 32;

  // Opcodes 7..13 are reserved and execute as NOP.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_NOP  = 4'd14,
    OP_HALT = 4'd15
  } alu_op_e;

  // op is kept as a raw field so reserved encodings survive decode untouched.
  typedef struct packed {
    logic [3:0]           op;
    logic [IMM_WIDTH-1:0] imm_a;
    logic [IMM_WIDTH-1:0] imm_b;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/simple_core_decode.sv
// Instruction decode: opcode class flags and sign-extended immediates.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its input every cycle.
// Ports: instr (instruction word) -> op, operand_a/operand_b, is_alu/is_nop/is_halt.
module simple_core_decode
  import simple_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  instr_t                instr,
  output logic [3:0]            op,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic                  is_alu,
  output logic                  is_nop,
  output logic                  is_halt
);

  always_comb begin
    op        = instr.op;
    operand_a = {{(DATA_WIDTH-IMM_WIDTH){instr.imm_a[IMM_WIDTH-1]}}, instr.imm_a};
    operand_b = {{(DATA_WIDTH-IMM_WIDTH){instr.imm_b[IMM_WIDTH-1]}}, instr.imm_b};
    is_halt   = (instr.op == OP_HALT);
    is_alu    = (instr.op <= OP_SHR);
    // Everything that is neither an ALU op nor HALT (reserved + NOP) is a bubble.
    is_nop    = !is_alu && !is_halt;
  end

endmodule

// File: rtl/simple_core_sequencer.sv
// Program sequencer: fetches from a sync-read ROM, decodes, issues one ALU op per cycle, drains on HALT.
// Latency: start -> ROM read next cycle -> first op on issue outputs the cycle after.
// Backpressure: issue_ready_i=0 freezes ir/pc/issue outputs and stalls fetch; drain counts only ready cycles.
// Ports: clk/n_reset, start_i, ROM (instr_addr_o, instr_rd_o, instr_i), ALU issue (issue_valid_o,
//        issue_ready_i, op_o, operand_a_o, operand_b_o), status (busy_o, stop_o, issued_count_o).
module simple_core_sequencer
  import simple_core_pkg::*;
#(
  parameter int PROG_DEPTH      = 8,
  parameter int PIPELINE_LENGTH = 2,
  parameter int DATA_WIDTH      = 32,
  localparam int AW             = $clog2(PROG_DEPTH)
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   start_i,
  output logic [AW-1:0]          instr_addr_o,
  output logic                   instr_rd_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [3:0]             op_o,
  output logic [DATA_WIDTH-1:0]  operand_a_o,
  output logic [DATA_WIDTH-1:0]  operand_b_o,
  output logic                   busy_o,
  output logic                   stop_o,
  output logic [15:0]            issued_count_o
);

  localparam int          PW     = AW + 1;
  localparam int          CW     = $clog2(PIPELINE_LENGTH + 1);
  localparam logic [PW-1:0] PC_END = PW'(PROG_DEPTH);

  seq_state_e             state_q, state_d;
  logic [PW-1:0]          pc_q;       // one extra bit marks "ROM exhausted" without wrapping
  logic                   ir_vld_q;
  logic                   fresh_q;    // ROM read last cycle: ir content is on instr_i right now
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [CW-1:0]          drain_q;
  logic [15:0]            cnt_q;

  logic [INSTR_WIDTH-1:0] ir_word;
  instr_t                 ir;
  logic [3:0]             dec_op;
  logic [DATA_WIDTH-1:0]  dec_a, dec_b;
  logic                   dec_alu, dec_nop, dec_halt;
  logic                   run, halt_now, consume, pc_end, slot_free, end_now, fetch, issue_fire;

  // The ROM output is itself registered, so the freshly read word is used in place for
  // zero-bubble issue; ir_q keeps it once the ROM moves on (e.g. across a stall).
  assign ir_word = fresh_q ? instr_i : ir_q;
  assign ir      = ir_word;

  simple_core_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr     (ir),
    .op        (dec_op),
    .operand_a (dec_a),
    .operand_b (dec_b),
    .is_alu    (dec_alu),
    .is_nop    (dec_nop),
    .is_halt   (dec_halt)
  );

  assign run        = (state_q == ST_RUN);
  assign halt_now   = run && ir_vld_q && dec_halt;
  assign consume    = run && ir_vld_q && (dec_nop || (dec_alu && issue_ready_i));
  assign pc_end     = (pc_q == PC_END);
  assign slot_free  = !ir_vld_q || consume;
  // Last ROM entry leaving ir with nothing left to fetch acts as an implicit HALT.
  assign end_now    = run && slot_free && pc_end;
  assign fetch      = run && slot_free && !pc_end;
  assign issue_fire = issue_valid_o && issue_ready_i;

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (halt_now || end_now) state_d = ST_DRAIN;
      ST_DRAIN: if (issue_ready_i && drain_q == CW'(1)) state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: issue_valid_o depends only on registered state and the registered ROM word.
  always_comb begin
    instr_rd_o     = fetch;
    instr_addr_o   = pc_end ? AW'(PROG_DEPTH - 1) : pc_q[AW-1:0];
    issue_valid_o  = run && ir_vld_q && dec_alu;
    op_o           = issue_valid_o ? dec_op : 4'd0;
    operand_a_o    = issue_valid_o ? dec_a : '0;
    operand_b_o    = issue_valid_o ? dec_b : '0;
    busy_o         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    stop_o         = (state_q == ST_DONE);
    issued_count_o = cnt_q;
  end

  // Datapath: pc, instruction register, drain counter, issue counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q     <= '0;
      ir_vld_q <= 1'b0;
      fresh_q  <= 1'b0;
      ir_q     <= '0;
      drain_q  <= '0;
      cnt_q    <= '0;
    end else if (start_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      pc_q     <= '0;
      ir_vld_q <= 1'b0;
      fresh_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (run) begin
        if (fetch) pc_q <= pc_q + PW'(1);
        fresh_q <= fetch;
        ir_q    <= ir_word;
        if (halt_now || end_now) begin
          ir_vld_q <= 1'b0;
          drain_q  <= CW'(PIPELINE_LENGTH);
        end else begin
          ir_vld_q <= fetch || (ir_vld_q && !consume);
        end
      end
      if (state_q == ST_DRAIN && issue_ready_i) drain_q <= drain_q - CW'(1);
      if (issue_fire && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_simple_core_sequencer.sv
// Bench for simple_core_sequencer: directed programs, expected issues queued, negedge monitor compares.
// Latency: n/a.
// Backpressure: issue_ready_i driven from per-test stall windows.
module tb_simple_core_sequencer;
  import simple_core_pkg::*;

  localparam int PD = 8;
  localparam int PL = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          start_i = 1'b0;
  logic [2:0]    instr_addr_o;
  logic          instr_rd_o;
  logic [31:0]   instr_i;
  logic          issue_valid_o;
  logic          issue_ready_i = 1'b1;
  logic [3:0]    op_o;
  logic [DW-1:0] operand_a_o, operand_b_o;
  logic          busy_o, stop_o;
  logic [15:0]   issued_count_o;

  always #5 clk = ~clk;

  simple_core_sequencer #(.PROG_DEPTH(PD), .PIPELINE_LENGTH(PL), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .start_i        (start_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rd_o     (instr_rd_o),
    .instr_i        (instr_i),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .op_o           (op_o),
    .operand_a_o    (operand_a_o),
    .operand_b_o    (operand_b_o),
    .busy_o         (busy_o),
    .stop_o         (stop_o),
    .issued_count_o (issued_count_o)
  );

  // Synchronous-read ROM model
  logic [31:0] rom [PD];
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)        instr_i <= '0;
    else if (instr_rd_o) instr_i <= rom[instr_addr_o];
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   mrel;
  int   reads, exp_addr, stop_cyc;
  bit   stop_seen, mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input int a, input int b);
    return {op, a[13:0], b[13:0]};
  endfunction

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int c);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && n_reset) begin
      mrel = cyc - t0;
      if (instr_rd_o) begin
        chk("fetch_addr", 64'(instr_addr_o), 64'(exp_addr));
        exp_addr++;
        reads++;
      end
      if (issue_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got op %0d a 0x%0h b 0x%0h, required no issue (rel cycle %0d)",
                   op_o, operand_a_o, operand_b_o, mrel);
        end else begin
          chk("issue_op", 64'(op_o), 64'(sb[0].op));
          chk("issue_a", 64'(operand_a_o), 64'(sb[0].a));
          chk("issue_b", 64'(operand_b_o), 64'(sb[0].b));
          if (issue_ready_i) begin
            chk("issue_cycle", 64'(mrel), 64'(sb[0].cyc));
            void'(sb.pop_front());
          end else begin
            chk("stall_no_fetch", 64'(instr_rd_o), 64'd0);
          end
        end
      end
      if (stop_o && !stop_seen) begin
        stop_seen = 1'b1;
        stop_cyc  = mrel;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {59'd0, instr_rd_o, issue_valid_o, busy_o, stop_o, 1'b0}, 64'd0);
    chk({tag, "_addr_op"}, {57'd0, instr_addr_o, op_o}, 64'd0);
    chk({tag, "_operands"}, {operand_a_o, operand_b_o}, 64'd0);
    chk({tag, "_count"}, 64'(issued_count_o), 64'd0);
  endtask

  task automatic do_start(input bit from_done);
    @(posedge clk); #1;
    start_i = 1'b1;
    issue_ready_i = 1'b1;
    t0 = cyc;
    exp_addr = 0;
    reads = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    stop_seen = 1'b0;
    if (from_done) begin
      chk("restart_stop_clear", 64'(stop_o), 64'd0);
      chk("restart_count_clear", 64'(issued_count_o), 64'd0);
    end
  endtask

  task automatic run_prog(input int stall_lo, input int stall_hi, input int start_at, input int budget);
    int rel;
    for (int k = 0; k < budget && !stop_seen; k++) begin
      rel = cyc - t0;
      issue_ready_i = !(rel >= stall_lo && rel <= stall_hi);
      start_i = (rel == start_at);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    issue_ready_i = 1'b1;
    chk("stop_reached", 64'(stop_seen), 64'd1);
  endtask

  task automatic finish_checks(input int exp_stop, input int exp_cnt, input int exp_reads);
    chk("stop_cycle", 64'(stop_cyc), 64'(exp_stop));
    chk("issued_count", 64'(issued_count_o), 64'(exp_cnt));
    chk("fetch_count", 64'(reads), 64'(exp_reads));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("busy_in_done", 64'(busy_o), 64'd0);
  endtask

  task automatic load_basic();
    rom[0] = mk(4'd0, 3, 5);
    rom[1] = mk(4'd1, 3, -2);
    rom[2] = mk(4'd14, 0, 0);
    rom[3] = mk(4'd15, 0, 0);
    for (int i = 4; i < PD; i++) rom[i] = mk(4'd2, 7, 7);
  endtask

  task automatic push_basic(input int sub_cyc);
    push(4'd0, 32'h0000_0003, 32'h0000_0005, 2);
    push(4'd1, 32'h0000_0003, 32'hFFFF_FFFE, sub_cyc);
  endtask

  initial begin
    // Reset
    #2 n_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    n_reset = 1'b1;

    // Basic program
    load_basic();
    push_basic(3);
    do_start(1'b0);
    run_prog(-1, -1, -1, 40);
    finish_checks(8, 2, 4);

    // Backpressure on SUB, plus a start pulse while running that must be ignored
    push(4'd0, 32'h0000_0003, 32'h0000_0005, 2);
    push(4'd1, 32'h0000_0003, 32'hFFFF_FFFE, 6);
    do_start(1'b1);
    run_prog(3, 5, 4, 40);
    finish_checks(11, 2, 4);

    // Restart from DONE reissues the same program
    push_basic(3);
    do_start(1'b1);
    run_prog(-1, -1, -1, 40);
    finish_checks(8, 2, 4);

    // No HALT: eight ADDs, implicit halt at end of ROM
    for (int i = 0; i < PD; i++) begin
      rom[i] = mk(4'd0, i + 1, -3 * (i + 1));
      push(4'd0, 32'(i + 1), 32'(-3 * (i + 1)), 2 + i);
    end
    do_start(1'b1);
    run_prog(-1, -1, -1, 60);
    finish_checks(12, 8, 8);

    // Reset mid-run, asynchronously between edges
    load_basic();
    push_basic(3);
    do_start(1'b1);
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b0;
    n_reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    push_basic(3);
    do_start(1'b0);
    run_prog(-1, -1, -1, 40);
    finish_checks(8, 2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
